// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = X - Y - Bin over WIDTH cycles, LSB first, start/done handshake.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output Ovf.
module serial_subtractor #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nx;
  logic [WIDTH-1:0] xs, ys, rs;
  logic             b;
  logic [CW-1:0]    cnt;
  logic             xi, yi, di, bn, last, accept;

  always_comb begin
    xi   = xs[0];
    yi   = ys[0];
    di   = xi ^ yi ^ b;
    bn   = (~xi & yi) | (~(xi ^ yi) & b);
    last = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xs   <= '0;
      ys   <= '0;
      rs   <= '0;
      b    <= 1'b0;
      cnt  <= '0;
      D    <= '0;
      Bout <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      Ovf  <= 1'b0;
`endif
    end else if (accept) begin
      xs  <= X;
      ys  <= Y;
      rs  <= '0;
      b   <= Bin;
      cnt <= '0;
    end else if (state == RUN) begin
      xs  <= xs >> 1;
      ys  <= ys >> 1;
      rs  <= {di, rs[WIDTH-1:1]};
      b   <= bn;
      cnt <= cnt + 1'b1;
      // Final bit goes straight into D so the result lands on the completion edge.
      if (last) begin
        D    <= {di, rs[WIDTH-1:1]};
        Bout <= bn;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        Ovf  <= b ^ bn;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=2 and WIDTH=8.
// Ovf checks are active only when SERIAL_SUBTRACTOR_OVF_EN is defined.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s2, b2, busy2, done2, bo2;
  logic [1:0] x2, y2, d2;
  logic       s8, b8, busy8, done8, bo8;
  logic [7:0] x8, y8, d8;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic       ov2, ov8;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(s2), .X(x2), .Y(y2), .Bin(b2),
    .busy(busy2), .done(done2), .D(d2), .Bout(bo2)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    , .Ovf(ov2)
`endif
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .X(x8), .Y(y8), .Bin(b8),
    .busy(busy8), .done(done8), .D(d8), .Bout(bo8)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    , .Ovf(ov8)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op2(input logic [1:0] x, input logic [1:0] y, input logic bi,
                     input logic [1:0] ed, input logic eb, input logic eo);
    int n;
    @(negedge clk);
    s2 = 1'b1; x2 = x; y2 = y; b2 = bi;
    @(posedge clk); #1;
    chk("acc_busy2", busy2, 1);
    chk("acc_done2", done2, 0);
    @(negedge clk);
    s2 = 1'b0; x2 = ~x; y2 = ~y; b2 = ~bi;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (done2) break;
      chk("run_busy2", busy2, 1);
    end
    chk("lat2", n, 2);
    chk("d2", d2, ed);
    chk("bout2", bo2, eb);
    chk("done_busy2", busy2, 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("ovf2", ov2, eo);
`endif
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic bi,
                     input logic [7:0] ed, input logic eb, input logic eo, input bit poke);
    int n;
    @(negedge clk);
    s8 = 1'b1; x8 = x; y8 = y; b8 = bi;
    @(posedge clk); #1;
    chk("acc_busy8", busy8, 1);
    chk("acc_done8", done8, 0);
    @(negedge clk);
    // A poke re-requests during RUN with different operands; it must be ignored.
    s8 = poke; x8 = poke ? 8'hFF : ~x; y8 = poke ? 8'h00 : ~y; b8 = ~bi;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (done8) break;
      chk("run_busy8", busy8, 1);
      @(negedge clk);
      s8 = 1'b0;
    end
    chk("lat8", n, 8);
    chk("d8", d8, ed);
    chk("bout8", bo8, eb);
    chk("done_busy8", busy8, 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("ovf8", ov8, eo);
`endif
  endtask

  initial begin
    logic [2:0] f2;
    logic [8:0] f8;
    logic [1:0] rx2, ry2;
    logic [7:0] rx8, ry8;
    logic       rb;
    int         r, seen;

    rst_n = 1'b0;
    s2 = 1'b0; x2 = '0; y2 = '0; b2 = 1'b0;
    s8 = 1'b0; x8 = '0; y8 = '0; b8 = 1'b0;
    #3;
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_d8", d8, 0);
    chk("rst_bout8", bo8, 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_d2", d2, 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("rst_ovf8", ov8, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // 0 - 2 - 1 wraps to 1 with borrow.
    op2(2'd0, 2'd2, 1'b1, 2'd1, 1'b1, 1'b0);
    // Back-to-back pair: second start is sampled during DONE.
    op2(2'd3, 2'd0, 1'b0, 2'd3, 1'b0, 1'b0);
    op2(2'd1, 2'd1, 1'b1, 2'd3, 1'b1, 1'b0);

    op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
    op8(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
    op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

    // Start re-pulsed during RUN is ignored.
    op8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("ignored_busy8", busy8, 0);
    chk("ignored_done8", done8, 0);
    chk("hold_d8", d8, 8'h0F);

    // Reset mid-RUN aborts the operation.
    @(negedge clk);
    s8 = 1'b1; x8 = 8'h20; y8 = 8'h01; b8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    s8 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy8", busy8, 0);
    chk("abort_d8", d8, 0);
    chk("abort_bout8", bo8, 0);
    chk("abort_done8", done8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8) seen++;
    end
    chk("abort_no_done8", seen, 0);
    op8(8'h20, 8'h01, 1'b0, 8'h1F, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      rx2 = 2'($urandom); ry2 = 2'($urandom); rb = 1'($urandom);
      f2 = {1'b0, rx2} - {1'b0, ry2} - {2'b0, rb};
      r = int'($signed(rx2)) - int'($signed(ry2)) - int'(rb);
      op2(rx2, ry2, rb, f2[1:0], f2[2], (r > 1 || r < -2));
    end
    for (int i = 0; i < 1000; i++) begin
      rx8 = 8'($urandom); ry8 = 8'($urandom); rb = 1'($urandom);
      f8 = {1'b0, rx8} - {1'b0, ry8} - {8'b0, rb};
      r = int'($signed(rx8)) - int'($signed(ry8)) - int'(rb);
      op8(rx8, ry8, rb, f8[7:0], f8[8], (r > 127 || r < -128), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial subtractor computing `D = X - Y - Bin` over `WIDTH` clock cycles, LSB first, with a start/done handshake. It is the inverse-operation counterpart to the team's ripple adder, built so the adder benches can cross-check sums by subtracting back. It sits beside the adder as a small arithmetic unit that trades latency for a single 1-bit full-subtractor datapath.

## Interface
- `WIDTH`, default 2: operand and result width in bits; legal range 2..32.
- `clk`  input  1  rising-edge clock; the block's only clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request pulse; sampled on rising `clk` edges.
- `X`  input  WIDTH  minuend; captured when `start` is accepted.
- `Y`  input  WIDTH  subtrahend; captured when `start` is accepted.
- `Bin`  input  1  borrow in; captured when `start` is accepted.
- `busy`  output  1  high while an operation is in progress.
- `done`  output  1  one-cycle completion pulse.
- `D`  output  WIDTH  difference, registered; holds its value between operations.
- `Bout`  output  1  borrow out: 1 iff `X < Y + Bin`, treating the operands as unsigned.
- `Ovf`  output  1  signed overflow; present only with the macro (see Configuration).

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: `busy`=0, `done`=0, `D`=0, `Bout`=0, `Ovf`=0. Internal shift registers, borrow flop and bit counter are cleared.
- IDLE or DONE, `start`=1: latch `X`, `Y` and `Bin` into the internal shift registers and borrow flop, clear the counter, go to RUN.
- IDLE, `start`=0: stay in IDLE. DONE, `start`=0: go to IDLE.
- RUN, one bit per cycle:
  - `d_i = x_i ^ y_i ^ b`
  - `b' = (~x_i & y_i) | (~(x_i ^ y_i) & b)`
  - `d_i` is shifted into the result shift register.
  - After bit `WIDTH-1`, load `D` from the result shift register, set `Bout` to the final borrow, then go to DONE.
- `start` is ignored while in RUN. No queueing; the operands in flight are unaffected.
- `D`, `Bout` and `Ovf` change only on the completion edge and hold until the next completion or reset.
- Arithmetic wraps modulo 2^WIDTH. For example, 0 - 2 - 1 with WIDTH=2 gives `D`=1, `Bout`=1.

## Timing
- Accept edge T: `start`=1 sampled in IDLE or DONE. `busy`=1 from T to T+WIDTH.
- Bit i is processed on edge T+1+i, for i = 0..WIDTH-1.
- Completion edge is T+WIDTH. On that edge `D`/`Bout` update and `done` rises; `done` is high for exactly one cycle.
- Latency from `start` accepted to `done` high is WIDTH cycles.
- Throughput is one operation per WIDTH+1 cycles. A back-to-back `start` sampled during DONE is accepted, so `done` falls and `busy` rises on the same edge.
- `rst_n` low at any time (including mid-RUN) immediately forces all outputs to their reset values and the FSM to IDLE. The aborted operation never produces `done`.
- `rst_n` deassertion is synchronized externally. The block only requires `start`=0 on the first edge after release.

## Configuration
- Macro: `SERIAL_SUBTRACTOR_OVF_EN`.
- Defined:
  - The `Ovf` port exists.
  - On the completion edge, `Ovf` = (borrow into bit WIDTH-1) XOR (borrow out of bit WIDTH-1), i.e. two's-complement overflow of `X - Y - Bin`.
  - `Ovf` holds like `D` and resets to 0.
- Undefined: the `Ovf` port and its borrow-into-MSB flop are absent. All other behaviour is identical.

## Test plan
- WIDTH=2; X=0, Y=2, Bin=1, `start` pulsed at T -> `busy` high T..T+2, `done` high one cycle after T+2, `D`=1, `Bout`=1.
- WIDTH=2; X=3, Y=0, Bin=0, then (back-to-back `start` during DONE) X=1, Y=1, Bin=1 -> first result `D`=3, `Bout`=0; second `done` 2 cycles later with `D`=3, `Bout`=1; no idle cycle between the two operations.
- WIDTH=8, `SERIAL_SUBTRACTOR_OVF_EN` defined:
  - X=0x80, Y=0x01, Bin=0 -> `D`=0x7F, `Bout`=0, `Ovf`=1.
  - X=0x7F, Y=0xFF, Bin=0 -> `D`=0x80, `Bout`=1, `Ovf`=1.
  - X=0x05, Y=0x03, Bin=0 -> `D`=0x02, `Ovf`=0.
- WIDTH=8; `start` with X=0x10, Y=0x01, then `start` re-pulsed with X=0xFF, Y=0x00 during RUN -> `done` after exactly 8 cycles with `D`=0x0F, `Bout`=0; second request ignored.
- WIDTH=8; previous result `D`=0x0F; new op started and `rst_n` pulsed low during the third RUN cycle -> `D`=0, `Bout`=0, `busy`=0 asynchronously; no `done` afterwards; next `start` runs normally.
- Random regression, WIDTH=2 and WIDTH=8, 1000 ops -> {`Bout`,`D`} equals {1'b0,X} - {1'b0,Y} - Bin modulo 2^(WIDTH+1) every time; `done` asserted exactly WIDTH cycles after each accepted `start`.
